// File: rtl/reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the system reset. Bounded retries on lock timeout, terminal FAIL after MAX_RETRY.
module reset_sequencer #(
    parameter int PRST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       pllRst,
    output logic       sysRst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retries
);

    localparam int MAX_AB = (PRST_CYCLES > LOCK_TIMEOUT) ? PRST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] PRST_LAST = CW'(PRST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PRST  = 3'd0,
        S_WLOCK = 3'd1,
        S_STAB  = 3'd2,
        S_RUN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [2:0]    retries_q, retries_d, retries_inc_s;
    logic          sync1_q, sync2_q;
    logic          pll_rst_q, sys_rst_q, ready_q, fail_q;

    assign cnt_inc_s     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    assign retries_inc_s = (retries_q == RETRY_MAX) ? retries_q : retries_q + 3'd1;

    // Next-state logic; the counter reloads whenever the state changes.
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        cnt_d     = cnt_inc_s;
        case (state_q)
            S_PRST: begin
                if (cnt_q == PRST_LAST) state_d = S_WLOCK;
                else                    state_d = S_PRST;
            end
            S_WLOCK: begin
                // Lock wins over a timeout landing on the same cycle.
                if (sync2_q) begin
                    state_d = S_STAB;
                end else if (cnt_q == LOCK_LAST) begin
                    retries_d = retries_inc_s;
                    if (retries_inc_s == RETRY_MAX) state_d = S_FAIL;
                    else                            state_d = S_PRST;
                end else begin
                    state_d = S_WLOCK;
                end
            end
            S_STAB: begin
                if (!sync2_q) begin
                    state_d = S_WLOCK;
                end else if (cnt_q == STAB_LAST) begin
                    state_d   = S_RUN;
                    retries_d = 3'd0;
                end else begin
                    state_d = S_STAB;
                end
            end
            S_RUN: begin
                if (!sync2_q) state_d = S_PRST;
                else          state_d = S_RUN;
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_PRST;
        endcase
        if (state_d != state_q) cnt_d = {CW{1'b0}};
        else                    cnt_d = cnt_d;
    end

    // State, synchronizer and outputs; outputs decode the next state so they switch on the transition edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= S_PRST;
            cnt_q     <= {CW{1'b0}};
            retries_q <= 3'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            sync1_q   <= locked;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            pll_rst_q <= (state_d == S_PRST);
            sys_rst_q <= (state_d == S_RUN);
            ready_q   <= (state_d == S_RUN);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign pllRst  = pll_rst_q;
    assign sysRst  = sys_rst_q;
    assign ready   = ready_q;
    assign fail    = fail_q;
    assign retries = retries_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with PRST=4, TIMEOUT=32, STABLE=8, MAX_RETRY=2.
// Edge numbers in the stimulus count rising edges since the last reset release.
module tb_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       locked;
    logic       pllRst;
    logic       sysRst;
    logic       ready;
    logic       fail;
    logic [2:0] retries;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    reset_sequencer #(
        .PRST_CYCLES  (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .locked (locked),
        .pllRst (pllRst),
        .sysRst (sysRst),
        .ready  (ready),
        .fail   (fail),
        .retries(retries)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Assert reset between edges and verify the reset values appear with no clock edge.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #2;
        chk({tag, "_pllRst"},  32'(pllRst),  32'd1);
        chk({tag, "_sysRst"},  32'(sysRst),  32'd0);
        chk({tag, "_ready"},   32'(ready),   32'd0);
        chk({tag, "_fail"},    32'(fail),    32'd0);
        chk({tag, "_retries"}, 32'(retries), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        locked = 1'b0;
        #25;
        async_reset("por");
        release_reset();

        // Nominal lock: locked after edge 10 -> STAB at 13 -> RUN at 21.
        tick(3);  chk("nom_prst_e3", 32'(pllRst), 32'd1);
        tick(1);  chk("nom_prst_e4", 32'(pllRst), 32'd0);
        tick(6);  locked = 1'b1;
        tick(10); chk("nom_ready_e20", 32'(ready), 32'd0);
                  chk("nom_sys_e20",   32'(sysRst), 32'd0);
        tick(1);  chk("nom_ready_e21", 32'(ready), 32'd1);
                  chk("nom_sys_e21",   32'(sysRst), 32'd1);
                  chk("nom_retries",   32'(retries), 32'd0);

        // Lock loss in RUN: locked low between edges 23 and 24.
        tick(2);  locked = 1'b0;
        tick(1);  locked = 1'b1;
        tick(1);  chk("loss_sys_e25",  32'(sysRst), 32'd1);
        tick(1);  chk("loss_sys_e26",  32'(sysRst), 32'd0);
                  chk("loss_rdy_e26",  32'(ready),  32'd0);
                  chk("loss_pll_e26",  32'(pllRst), 32'd1);
        tick(3);  chk("loss_pll_e29",  32'(pllRst), 32'd1);
        tick(1);  chk("loss_pll_e30",  32'(pllRst), 32'd0);
        tick(8);  chk("loss_rdy_e38",  32'(ready),  32'd0);
        tick(1);  chk("loss_rdy_e39",  32'(ready),  32'd1);

        // Lock chatter: STAB entered at 5, glitch aborts it at 9, RUN only at 18.
        tick(1);  async_reset("rst_run");
        locked = 1'b1;
        release_reset();
        tick(6);  locked = 1'b0;
        tick(1);  locked = 1'b1;
        tick(6);  chk("chat_rdy_e13", 32'(ready), 32'd0);
        tick(4);  chk("chat_rdy_e17", 32'(ready), 32'd0);
        tick(1);  chk("chat_rdy_e18", 32'(ready), 32'd1);
                  chk("chat_retries", 32'(retries), 32'd0);

        // No lock: timeouts at edges 36 and 72, FAIL from 72.
        tick(1);  async_reset("rst_chat");
        locked = 1'b0;
        release_reset();
        tick(35); chk("nol_pll_e35",  32'(pllRst),  32'd0);
                  chk("nol_ret_e35",  32'(retries), 32'd0);
        tick(1);  chk("nol_pll_e36",  32'(pllRst),  32'd1);
                  chk("nol_ret_e36",  32'(retries), 32'd1);
        tick(3);  chk("nol_pll_e39",  32'(pllRst),  32'd1);
        tick(1);  chk("nol_pll_e40",  32'(pllRst),  32'd0);
        tick(31); chk("nol_fail_e71", 32'(fail),    32'd0);
        tick(1);  chk("nol_fail_e72", 32'(fail),    32'd1);
                  chk("nol_ret_e72",  32'(retries), 32'd2);
                  chk("nol_pll_e72",  32'(pllRst),  32'd0);
                  chk("nol_sys_e72",  32'(sysRst),  32'd0);
        locked = 1'b1;
        tick(40); chk("nol_fail_hold", 32'(fail),    32'd1);
                  chk("nol_ret_hold",  32'(retries), 32'd2);
                  chk("nol_sys_hold",  32'(sysRst),  32'd0);
                  chk("nol_rdy_hold",  32'(ready),   32'd0);
        async_reset("rst_fail");
        locked = 1'b0;
        release_reset();

        // Timeout tie: locked after edge 33 makes locked_s first seen at edge 36, the timeout cycle.
        tick(33); locked = 1'b1;
        tick(3);  chk("tie_ret_e36", 32'(retries), 32'd0);
                  chk("tie_pll_e36", 32'(pllRst),  32'd0);
        tick(7);  chk("tie_rdy_e43", 32'(ready),   32'd0);
        tick(1);  chk("tie_rdy_e44", 32'(ready),   32'd1);

        // Async reset while in STAB, then a clean restart.
        tick(1);  async_reset("rst_pre");
        release_reset();
        tick(6);  async_reset("rst_stab");
        locked = 1'b0;
        release_reset();
        tick(3);  chk("rst_pll_e3", 32'(pllRst), 32'd1);
        tick(1);  chk("rst_pll_e4", 32'(pllRst), 32'd0);
                  chk("rst_fail",   32'(fail),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
